// File: rtl/multi_source_recovery_controller.sv
// Recovery controller: picks the oldest of NUM_SRC recovery requests, runs the COMMIT/RECOVER phase FSM
// and broadcasts the flush range, refetch PC and LSQ tails. Optional perf counters: RECOVERY_PERF_COUNTER_EN.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_COMMIT  | normal commit phase, requests may be accepted
// ST_ENTER   | first RECOVER cycle, to_recovery_phase pulse, busy ignored
// ST_RECOVER | waiting for sub-units idle and minimum dwell time
// ST_EXIT    | back in COMMIT phase, to_commit_phase pulse, requests rejected
module multi_source_recovery_controller #(
  parameter int NUM_SRC        = 3,
  parameter int NUM_BUSY       = 4,
  parameter int AL_W           = 6,
  parameter int LQ_W           = 4,
  parameter int SQ_W           = 4,
  parameter int ADDR_W         = 32,
  parameter int MIN_REC_CYCLES = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC-1:0]        src_req,
  input  logic [NUM_SRC*AL_W-1:0]   src_al_ptr,
  input  logic [NUM_SRC-1:0]        src_refetch_next,
  input  logic [NUM_SRC*ADDR_W-1:0] src_pc,
  input  logic [NUM_SRC*LQ_W-1:0]   src_lq_tail,
  input  logic [NUM_SRC*SQ_W-1:0]   src_sq_tail,
  input  logic [AL_W-1:0]           al_head_ptr,
  input  logic [AL_W-1:0]           al_tail_ptr,
  input  logic [NUM_BUSY-1:0]       busy,
  output logic                      phase,
  output logic                      to_recovery_phase,
  output logic                      to_commit_phase,
  output logic [AL_W-1:0]           flush_head_ptr,
  output logic [AL_W-1:0]           flush_tail_ptr,
  output logic [ADDR_W-1:0]         recovered_pc,
  output logic [LQ_W-1:0]           lq_recovery_tail,
  output logic [SQ_W-1:0]           sq_recovery_tail,
  output logic [NUM_SRC-1:0]        recovery_src,
  output logic                      unable_to_start_recovery
`ifdef RECOVERY_PERF_COUNTER_EN
  ,
  output logic [NUM_SRC*32-1:0]     perf_rec_count,
  output logic [31:0]               perf_rec_cycles
`endif
);

  localparam int CNT_W = $clog2(MIN_REC_CYCLES + 1);
  localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_REC_CYCLES);

  typedef enum logic [1:0] {
    ST_COMMIT  = 2'd0,
    ST_ENTER   = 2'd1,
    ST_RECOVER = 2'd2,
    ST_EXIT    = 2'd3
  } stateT;

  stateT state;
  stateT stateNext;

  logic [CNT_W-1:0]   recCnt;
  logic               accept;
  logic               exitOk;

  logic [AL_W-1:0]    srcAge;
  logic               winFound;
  logic [AL_W-1:0]    winAge;
  logic [NUM_SRC-1:0] winOneHot;
  logic [AL_W-1:0]    winPtr;
  logic               winRefetch;
  logic [ADDR_W-1:0]  winPc;
  logic [LQ_W-1:0]    winLq;
  logic [SQ_W-1:0]    winSq;

  // Age is distance from the AL head; strict '<' keeps the lowest index on ties.
  always_comb begin
    srcAge     = '0;
    winFound   = 1'b0;
    winAge     = '0;
    winOneHot  = '0;
    winPtr     = '0;
    winRefetch = 1'b0;
    winPc      = '0;
    winLq      = '0;
    winSq      = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      srcAge = src_al_ptr[i*AL_W +: AL_W] - al_head_ptr;
      if (src_req[i] && (!winFound || (srcAge < winAge))) begin
        winFound     = 1'b1;
        winAge       = srcAge;
        winOneHot    = '0;
        winOneHot[i] = 1'b1;
        winPtr       = src_al_ptr[i*AL_W +: AL_W];
        winRefetch   = src_refetch_next[i];
        winPc        = src_pc[i*ADDR_W +: ADDR_W];
        winLq        = src_lq_tail[i*LQ_W +: LQ_W];
        winSq        = src_sq_tail[i*SQ_W +: SQ_W];
      end
    end
  end

  assign accept = (state == ST_COMMIT) && (|src_req);
  assign exitOk = (state == ST_RECOVER) && (busy == '0) && (recCnt >= MIN_CNT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_COMMIT;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      ST_COMMIT:  if (accept) stateNext = ST_ENTER;
      ST_ENTER:   stateNext = ST_RECOVER;
      ST_RECOVER: if (exitOk) stateNext = ST_EXIT;
      ST_EXIT:    stateNext = ST_COMMIT;
      default:    stateNext = ST_COMMIT;
    endcase
  end

  always_comb begin
    phase                    = (state == ST_ENTER) || (state == ST_RECOVER);
    to_recovery_phase        = (state == ST_ENTER);
    to_commit_phase          = (state == ST_EXIT);
    unable_to_start_recovery = (|src_req) && !accept;
  end

  // Captured recovery context holds until the next accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_head_ptr   <= '0;
      flush_tail_ptr   <= '0;
      recovered_pc     <= '0;
      lq_recovery_tail <= '0;
      sq_recovery_tail <= '0;
      recovery_src     <= '0;
      recCnt           <= '0;
    end else if (accept) begin
      flush_head_ptr   <= winPtr + AL_W'(winRefetch);
      flush_tail_ptr   <= al_tail_ptr;
      recovered_pc     <= winPc;
      lq_recovery_tail <= winLq;
      sq_recovery_tail <= winSq;
      recovery_src     <= winOneHot;
      recCnt           <= '0;
    end else if (phase && (recCnt < MIN_CNT)) begin
      recCnt <= recCnt + CNT_W'(1);
    end
  end

`ifdef RECOVERY_PERF_COUNTER_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_rec_count  <= '0;
      perf_rec_cycles <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (accept && winOneHot[i]) begin
          perf_rec_count[i*32 +: 32] <= perf_rec_count[i*32 +: 32] + 32'd1;
        end
      end
      if (phase) begin
        perf_rec_cycles <= perf_rec_cycles + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_multi_source_recovery_controller.sv
// Self-checking bench for multi_source_recovery_controller: directed scenarios plus randomized
// recoveries checked against an age/timing reference model.
module tb_multi_source_recovery_controller;
  localparam int NUM_SRC  = 3;
  localparam int NUM_BUSY = 4;
  localparam int AL_W     = 6;
  localparam int LQ_W     = 4;
  localparam int SQ_W     = 4;
  localparam int ADDR_W   = 32;
  localparam int MIN_REC  = 2;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NUM_SRC-1:0]        src_req;
  logic [NUM_SRC*AL_W-1:0]   src_al_ptr;
  logic [NUM_SRC-1:0]        src_refetch_next;
  logic [NUM_SRC*ADDR_W-1:0] src_pc;
  logic [NUM_SRC*LQ_W-1:0]   src_lq_tail;
  logic [NUM_SRC*SQ_W-1:0]   src_sq_tail;
  logic [AL_W-1:0]           al_head_ptr;
  logic [AL_W-1:0]           al_tail_ptr;
  logic [NUM_BUSY-1:0]       busy;
  logic                      phase;
  logic                      to_recovery_phase;
  logic                      to_commit_phase;
  logic [AL_W-1:0]           flush_head_ptr;
  logic [AL_W-1:0]           flush_tail_ptr;
  logic [ADDR_W-1:0]         recovered_pc;
  logic [LQ_W-1:0]           lq_recovery_tail;
  logic [SQ_W-1:0]           sq_recovery_tail;
  logic [NUM_SRC-1:0]        recovery_src;
  logic                      unable_to_start_recovery;

  always #5 clk = ~clk;

  multi_source_recovery_controller #(
    .NUM_SRC(NUM_SRC), .NUM_BUSY(NUM_BUSY), .AL_W(AL_W), .LQ_W(LQ_W),
    .SQ_W(SQ_W), .ADDR_W(ADDR_W), .MIN_REC_CYCLES(MIN_REC)
  ) dut (
    .clk(clk), .rst(rst), .src_req(src_req), .src_al_ptr(src_al_ptr),
    .src_refetch_next(src_refetch_next), .src_pc(src_pc), .src_lq_tail(src_lq_tail),
    .src_sq_tail(src_sq_tail), .al_head_ptr(al_head_ptr), .al_tail_ptr(al_tail_ptr),
    .busy(busy), .phase(phase), .to_recovery_phase(to_recovery_phase),
    .to_commit_phase(to_commit_phase), .flush_head_ptr(flush_head_ptr),
    .flush_tail_ptr(flush_tail_ptr), .recovered_pc(recovered_pc),
    .lq_recovery_tail(lq_recovery_tail), .sq_recovery_tail(sq_recovery_tail),
    .recovery_src(recovery_src), .unable_to_start_recovery(unable_to_start_recovery)
  );

  int nCompared   = 0;
  int nMismatched = 0;

  logic [AL_W-1:0]     ptrA [NUM_SRC];
  logic [ADDR_W-1:0]   pcA  [NUM_SRC];
  logic [LQ_W-1:0]     lqA  [NUM_SRC];
  logic [SQ_W-1:0]     sqA  [NUM_SRC];
  logic [NUM_SRC-1:0]  reqV, rfnV;
  logic [AL_W-1:0]     headV, tailV;
  logic [NUM_BUSY-1:0] busyPat[$];

  logic [ADDR_W-1:0]   expPc;
  logic [AL_W-1:0]     expHead, expTail;
  logic [LQ_W-1:0]     expLq;
  logic [SQ_W-1:0]     expSq;
  logic [NUM_SRC-1:0]  expSrc;

  task automatic drive_sources();
    for (int i = 0; i < NUM_SRC; i++) begin
      src_al_ptr[i*AL_W +: AL_W]     = ptrA[i];
      src_pc[i*ADDR_W +: ADDR_W]     = pcA[i];
      src_lq_tail[i*LQ_W +: LQ_W]    = lqA[i];
      src_sq_tail[i*SQ_W +: SQ_W]    = sqA[i];
    end
    src_req          = reqV;
    src_refetch_next = rfnV;
    al_head_ptr      = headV;
    al_tail_ptr      = tailV;
  endtask

  task automatic randomize_sources();
    for (int i = 0; i < NUM_SRC; i++) begin
      ptrA[i] = AL_W'($urandom);
      pcA[i]  = $urandom;
      lqA[i]  = LQ_W'($urandom);
      sqA[i]  = SQ_W'($urandom);
    end
    rfnV  = NUM_SRC'($urandom);
    headV = AL_W'($urandom);
    tailV = AL_W'($urandom);
  endtask

  // Reference: oldest = smallest distance from the AL head, lowest index first on ties.
  function automatic int oldest(input logic [NUM_SRC-1:0] req);
    int best;
    int bestAge;
    int a;
    best = -1;
    bestAge = 0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (req[i]) begin
        a = (int'(ptrA[i]) - int'(headV) + (1 << AL_W)) % (1 << AL_W);
        if (best < 0 || a < bestAge) begin
          best = i;
          bestAge = a;
        end
      end
    end
    return best;
  endfunction

  task automatic set_expect_from(input int w);
    expSrc    = '0;
    expSrc[w] = 1'b1;
    expHead   = AL_W'((int'(ptrA[w]) + int'(rfnV[w])) % (1 << AL_W));
    expTail   = tailV;
    expPc     = pcA[w];
    expLq     = lqA[w];
    expSq     = sqA[w];
  endtask

  // Called at a negedge in COMMIT phase; returns at the negedge of the entry cycle.
  task automatic launch(input string tag);
    int w;
    w = oldest(reqV);
    set_expect_from(w);
    drive_sources();
    #1;
    nCompared++;
    if (unable_to_start_recovery !== 1'b0) begin
      nMismatched++;
      $display("FAIL %s accept_unable: got %b want 0", tag, unable_to_start_recovery);
    end
    @(negedge clk);
    reqV = '0;
    randomize_sources();
    drive_sources();
    nCompared++;
    if ({phase, to_recovery_phase, to_commit_phase} !== 3'b110) begin
      nMismatched++;
      $display("FAIL %s entry_pulse: got phase/torec/tocom=%b want 110", tag,
               {phase, to_recovery_phase, to_commit_phase});
    end
    nCompared++;
    if (recovery_src !== expSrc) begin
      nMismatched++;
      $display("FAIL %s recovery_src: got %b want %b", tag, recovery_src, expSrc);
    end
    nCompared++;
    if (flush_head_ptr !== expHead || flush_tail_ptr !== expTail) begin
      nMismatched++;
      $display("FAIL %s flush_range: got %0d..%0d want %0d..%0d", tag,
               flush_head_ptr, flush_tail_ptr, expHead, expTail);
    end
    nCompared++;
    if (recovered_pc !== expPc || lq_recovery_tail !== expLq || sq_recovery_tail !== expSq) begin
      nMismatched++;
      $display("FAIL %s capture: got pc=%h lq=%0d sq=%0d want pc=%h lq=%0d sq=%0d", tag,
               recovered_pc, lq_recovery_tail, sq_recovery_tail, expPc, expLq, expSq);
    end
  endtask

  // Starts at the negedge of the entry cycle (k=0). Exit is the first cycle k >= MIN_REC (and >= 1)
  // with busy clear; the commit pulse appears in cycle k+1.
  task automatic finish_recovery(input string tag, input bit holdReq, input bit randReq);
    int exitK;
    int k;
    exitK = (MIN_REC > 1) ? MIN_REC : 1;
    while (exitK < busyPat.size() && busyPat[exitK] != '0) exitK++;
    k = 0;
    while (k <= exitK) begin
      busy = (k < busyPat.size()) ? busyPat[k] : '0;
      if (randReq) src_req = NUM_SRC'($urandom);
      else if (holdReq) src_req = 3'b001;
      else src_req = '0;
      #1;
      nCompared++;
      if (unable_to_start_recovery !== (|src_req)) begin
        nMismatched++;
        $display("FAIL %s rec_unable k=%0d: got %b want %b", tag, k, unable_to_start_recovery, |src_req);
      end
      @(negedge clk);
      k++;
      nCompared++;
      if (k <= exitK) begin
        if ({phase, to_recovery_phase, to_commit_phase} !== 3'b100) begin
          nMismatched++;
          $display("FAIL %s in_recover k=%0d: got phase/torec/tocom=%b want 100", tag, k,
                   {phase, to_recovery_phase, to_commit_phase});
        end
      end else begin
        if ({phase, to_recovery_phase, to_commit_phase} !== 3'b001) begin
          nMismatched++;
          $display("FAIL %s commit_pulse k=%0d: got phase/torec/tocom=%b want 001", tag, k,
                   {phase, to_recovery_phase, to_commit_phase});
        end
      end
      nCompared++;
      if (recovered_pc !== expPc || recovery_src !== expSrc || flush_head_ptr !== expHead) begin
        nMismatched++;
        $display("FAIL %s hold k=%0d: got pc=%h src=%b head=%0d want pc=%h src=%b head=%0d", tag, k,
                 recovered_pc, recovery_src, flush_head_ptr, expPc, expSrc, expHead);
      end
    end
    busy = '0;
    #1;
    nCompared++;
    if (unable_to_start_recovery !== (|src_req)) begin
      nMismatched++;
      $display("FAIL %s commit_cycle_unable: got %b want %b", tag, unable_to_start_recovery, |src_req);
    end
    if (!holdReq) begin
      src_req = '0;
      @(negedge clk);
      nCompared++;
      if ({phase, to_recovery_phase, to_commit_phase} !== 3'b000) begin
        nMismatched++;
        $display("FAIL %s settle: got phase/torec/tocom=%b want 000", tag,
                 {phase, to_recovery_phase, to_commit_phase});
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    busy = '0;
    reqV = '0;
    randomize_sources();
    drive_sources();
    repeat (2) @(negedge clk);
    nCompared++;
    if ({phase, to_recovery_phase, to_commit_phase} !== 3'b000 || flush_head_ptr !== '0 ||
        recovery_src !== '0 || recovered_pc !== '0) begin
      nMismatched++;
      $display("FAIL reset_init: got pulses=%b head=%0d src=%b pc=%h want all zero",
               {phase, to_recovery_phase, to_commit_phase}, flush_head_ptr, recovery_src, recovered_pc);
    end
    rst = 1'b0;
    randomize_sources();
    reqV = 3'b010;
    launch("reset_mid");
    busy = 4'b0011;
    repeat (2) @(negedge clk);
    nCompared++;
    if (phase !== 1'b1) begin
      nMismatched++;
      $display("FAIL reset_pre_phase: got %b want 1", phase);
    end
    rst = 1'b1;
    #1;
    nCompared++;
    if ({phase, to_recovery_phase, to_commit_phase} !== 3'b000 || flush_head_ptr !== '0 ||
        recovery_src !== '0) begin
      nMismatched++;
      $display("FAIL reset_async: got pulses=%b head=%0d src=%b want 000/0/0",
               {phase, to_recovery_phase, to_commit_phase}, flush_head_ptr, recovery_src);
    end
    @(negedge clk);
    rst = 1'b0;
    busy = '0;
  endtask

  task automatic test_single();
    randomize_sources();
    headV = 6'd10; tailV = 6'd20; reqV = 3'b010;
    ptrA[1] = 6'd12; rfnV = 3'b010; pcA[1] = 32'h1000;
    launch("single");
    nCompared++;
    if (flush_head_ptr !== 6'd13 || recovery_src !== 3'b010 || flush_tail_ptr !== 6'd20) begin
      nMismatched++;
      $display("FAIL single_const: got head=%0d tail=%0d src=%b want 13/20/010",
               flush_head_ptr, flush_tail_ptr, recovery_src);
    end
    busyPat = {};
    finish_recovery("single", 1'b0, 1'b0);
  endtask

  task automatic test_oldest_wrap();
    randomize_sources();
    headV = 6'd60; reqV = 3'b101; rfnV = 3'b000;
    ptrA[0] = 6'd5; ptrA[2] = 6'd62;
    launch("wrap");
    nCompared++;
    if (recovery_src !== 3'b100 || flush_head_ptr !== 6'd62) begin
      nMismatched++;
      $display("FAIL wrap_const: got src=%b head=%0d want 100/62", recovery_src, flush_head_ptr);
    end
    busyPat = {};
    finish_recovery("wrap", 1'b0, 1'b0);
  endtask

  task automatic test_tie();
    randomize_sources();
    headV = 6'd3; reqV = 3'b011; rfnV = 3'b000;
    ptrA[0] = 6'd7; ptrA[1] = 6'd7;
    launch("tie");
    nCompared++;
    if (recovery_src !== 3'b001 || flush_head_ptr !== 6'd7) begin
      nMismatched++;
      $display("FAIL tie_const: got src=%b head=%0d want 001/7", recovery_src, flush_head_ptr);
    end
    busyPat = {};
    finish_recovery("tie", 1'b0, 1'b0);
  endtask

  task automatic test_busy_hold();
    randomize_sources();
    reqV = 3'b100;
    launch("busy_hold");
    busyPat = {};
    for (int i = 0; i < 6; i++) busyPat.push_back(4'b0100);
    finish_recovery("busy_hold", 1'b0, 1'b0);
  endtask

  task automatic test_empty_range();
    randomize_sources();
    reqV = 3'b100; rfnV = 3'b000;
    tailV = ptrA[2];
    launch("empty");
    busyPat = {};
    finish_recovery("empty", 1'b0, 1'b0);
  endtask

  task automatic test_collision();
    randomize_sources();
    reqV = 3'b001;
    launch("collision");
    busyPat = {4'b0001, 4'b0001, 4'b0000, 4'b1000};
    finish_recovery("collision", 1'b1, 1'b0);
    reqV = 3'b001;
    set_expect_from(oldest(reqV));
    @(negedge clk);
    nCompared++;
    if ({phase, to_recovery_phase, to_commit_phase} !== 3'b000 || unable_to_start_recovery !== 1'b0) begin
      nMismatched++;
      $display("FAIL collision_accept: got pulses=%b unable=%b want 000/0",
               {phase, to_recovery_phase, to_commit_phase}, unable_to_start_recovery);
    end
    @(negedge clk);
    src_req = '0;
    nCompared++;
    if (to_recovery_phase !== 1'b1 || recovery_src !== 3'b001 || recovered_pc !== expPc) begin
      nMismatched++;
      $display("FAIL collision_reentry: got torec=%b src=%b pc=%h want 1/001/%h",
               to_recovery_phase, recovery_src, recovered_pc, expPc);
    end
    busyPat = {};
    finish_recovery("collision2", 1'b0, 1'b0);
  endtask

  task automatic test_random();
    int n;
    for (int t = 0; t < 40; t++) begin
      randomize_sources();
      reqV = NUM_SRC'($urandom_range(1, (1 << NUM_SRC) - 1));
      launch("random");
      busyPat = {};
      n = $urandom_range(0, 7);
      for (int i = 0; i < n; i++)
        busyPat.push_back(($urandom_range(0, 1) == 1) ? NUM_BUSY'($urandom) : '0);
      finish_recovery("random", 1'b0, $urandom_range(0, 1) == 1);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_oldest_wrap();
    test_tie();
    test_busy_hold();
    test_empty_range();
    test_collision();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
